pc_sequencer: RTL

Fetch-stage controller that computes `PC_new` for the PC register every cycle. The PC register latches unconditionally on every clock edge, so holding, advancing and redirecting the PC are all decided here. The block arbitrates between sequential fetch, the EX-stage branch, the ID-stage jump and the hazard-unit stall. It also runs a run/step/halt FSM for debug, and holds a redirect that arrives while fetch is frozen until fetch resumes.

---
 rtl/pc_seq_pkg.sv | 14 +
 rtl/pc_next_sel.sv | 39 +++
 rtl/pc_sequencer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and defaults for the fetch-stage PC sequencer.
package pc_seq_pkg;

  localparam int unsigned ADDR_W_DEF = 10;
  localparam int unsigned CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    STEP_WAIT = 2'd2,
    HALTED    = 2'd3
  } state_e;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux: pending redirect, branch, jump, sequential, hold.
module pc_next_sel
  import pc_seq_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic [ADDR_W-1:0] pc_current_i,
  input  logic              advance_i,
  input  logic              pend_valid_i,
  input  logic [ADDR_W-1:0] pend_target_i,
  input  logic              branch_taken_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic              jump_i,
  input  logic [ADDR_W-1:0] jump_target_i,
  output logic [ADDR_W-1:0] next_pc_o,
  output logic              redirect_live_o,
  output logic [ADDR_W-1:0] live_target_o,
  output logic              redirect_applied_o
);

  // A held redirect marks everything behind it as wrong-path, so live ones are masked.
  always_comb begin
    redirect_live_o    = ~pend_valid_i & (branch_taken_i | jump_i);
    live_target_o      = branch_taken_i ? branch_target_i : jump_target_i;
    next_pc_o          = pc_current_i;
    redirect_applied_o = 1'b0;
    if (advance_i) begin
      redirect_applied_o = pend_valid_i | redirect_live_o;
      if (pend_valid_i) begin
        next_pc_o = pend_target_i;
      end else if (redirect_live_o) begin
        next_pc_o = live_target_o;
      end else begin
        next_pc_o = pc_current_i + ADDR_W'(1);
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage controller: run/step/halt FSM, pending redirect, fetch status and counter.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned RESET_VECTOR = 0,
  parameter int unsigned CNT_W        = CNT_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] PC_current,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              halt,
  input  logic              step_mode,
  input  logic              step_req,
  input  logic              resume,
  output logic [ADDR_W-1:0] PC_new,
  output logic              flush,
  output logic              fetch_valid,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  fetch_count
);

  localparam logic [ADDR_W-1:0] RV = ADDR_W'(RESET_VECTOR);

  state_e              state_q, state_d;
  logic                pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0]   pend_target_q, pend_target_d;
  logic                fetch_valid_q;
  logic [CNT_W-1:0]    fetch_count_q;
  logic                advance_c;
  logic [ADDR_W-1:0]   sel_pc;
  logic                redirect_live;
  logic [ADDR_W-1:0]   live_target;
  logic                redirect_applied;

  pc_next_sel #(.ADDR_W(ADDR_W)) u_sel (
    .pc_current_i       (PC_current),
    .advance_i          (advance_c),
    .pend_valid_i       (pend_valid_q),
    .pend_target_i      (pend_target_q),
    .branch_taken_i     (branch_taken),
    .branch_target_i    (branch_target),
    .jump_i             (jump),
    .jump_target_i      (jump_target),
    .next_pc_o          (sel_pc),
    .redirect_live_o    (redirect_live),
    .live_target_o      (live_target),
    .redirect_applied_o (redirect_applied)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A live redirect overrides both stall and halt; a step advance obeys the same rules as RUN.
  always_comb begin
    state_d   = state_q;
    advance_c = 1'b0;
    case (state_q)
      IDLE: state_d = step_mode ? STEP_WAIT : RUN;
      RUN: begin
        if (halt && !redirect_live) begin
          state_d = HALTED;
        end else if (step_mode) begin
          state_d = STEP_WAIT;
        end else begin
          advance_c = redirect_live || !stall;
        end
      end
      STEP_WAIT: begin
        if (step_req) begin
          if (halt && !redirect_live) begin
            state_d = HALTED;
          end else begin
            advance_c = redirect_live || !stall;
          end
        end else if (!step_mode) begin
          state_d = RUN;
        end
      end
      HALTED: begin
        if (resume) begin
          state_d = step_mode ? STEP_WAIT : RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Redirects seen while fetch is frozen are parked until the next advance.
  always_comb begin
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    if (advance_c) begin
      pend_valid_d = 1'b0;
    end else if (redirect_live && (state_q != IDLE)) begin
      pend_valid_d  = 1'b1;
      pend_target_d = live_target;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
      fetch_valid_q <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      fetch_valid_q <= advance_c;
      fetch_count_q <= fetch_count_q + CNT_W'(advance_c);
    end
  end

  assign PC_new      = (reset || (state_q == IDLE)) ? RV : sel_pc;
  assign flush       = !reset && redirect_applied;
  assign fetch_valid = fetch_valid_q;
  assign state       = state_q;
  assign fetch_count = fetch_count_q;

endmodule
